// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared state encoding, ld_type codes and bus widths for the memory stage
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_DONE  = 2'd2
  } ms_state_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4,
    LD_LWU = 3'd5,
    LD_LD  = 3'd6
  } ld_type_e;

  localparam int LD_TYPE_W = 3;

  // {pc, mem_req, load_op, ld_type, rf_we, rf_addr, alu_result}
  function automatic int es_to_ms_bus_wd(input int pc_w, input int rf_aw, input int data_w);
    return pc_w + 3 + LD_TYPE_W + rf_aw + data_w;
  endfunction

  // {pc, rf_we, rf_addr, rf_wdata}
  function automatic int ms_to_ws_bus_wd(input int pc_w, input int rf_aw, input int data_w);
    return pc_w + 1 + rf_aw + data_w;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// rtl/mem_stage_lsu_load_align.sv - load lane select and sign/zero extension
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [LD_TYPE_W-1:0]         ld_type,
  input  logic [$clog2(DATA_W/8)-1:0]  off,
  input  logic [DATA_W-1:0]            rdata,
  output logic [DATA_W-1:0]            data_o
);

  // Keep the low n bits of v and extend them to DATA_W; shifting up and back down avoids
  // zero-width replications when n == DATA_W.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input int n,
                                               input logic sgn);
    logic        [DATA_W-1:0] top;
    logic signed [DATA_W-1:0] stop;
    top  = v << (DATA_W - n);
    stop = top;
    if (sgn) extend = stop >>> (DATA_W - n);
    else     extend = top >> (DATA_W - n);
  endfunction

  logic [DATA_W-1:0] lane;

  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (ld_type)
      LD_LB:   data_o = extend(lane, 8, 1'b1);
      LD_LBU:  data_o = extend(lane, 8, 1'b0);
      LD_LH:   data_o = extend(lane, 16, 1'b1);
      LD_LHU:  data_o = extend(lane, 16, 1'b0);
      LD_LW:   data_o = extend(lane, 32, 1'b1);
      LD_LWU:  data_o = extend(lane, 32, 1'b0);
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - in-order memory stage: holds one entry, waits for data_ok, drops flushed responses
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RF_AW  = 5,
  parameter int DROP_W = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic                                          ws_allowin,
  output logic                                          ms_allowin,
  input  logic                                          es_to_ms_valid,
  input  logic [es_to_ms_bus_wd(PC_W, RF_AW, DATA_W)-1:0] es_to_ms_bus,
  output logic                                          ms_to_ws_valid,
  output logic [ms_to_ws_bus_wd(PC_W, RF_AW, DATA_W)-1:0] ms_to_ws_bus,
  input  logic                                          data_data_ok,
  input  logic [DATA_W-1:0]                             data_rdata,
  output logic                                          ms_fwd_we,
  output logic [RF_AW-1:0]                              ms_fwd_addr,
  output logic                                          ms_fwd_block
);

  localparam int ES_WD    = es_to_ms_bus_wd(PC_W, RF_AW, DATA_W);
  localparam int OFF_W    = $clog2(DATA_W/8);
  localparam int RFA_LSB  = DATA_W;
  localparam int RFWE_BIT = RFA_LSB + RF_AW;
  localparam int LDT_LSB  = RFWE_BIT + 1;
  localparam int LOAD_BIT = LDT_LSB + LD_TYPE_W;
  localparam int MREQ_BIT = LOAD_BIT + 1;
  localparam int PC_LSB   = MREQ_BIT + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  ms_state_e         state_q, state_d;
  logic [ES_WD-1:0]  bus_q, bus_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [PC_W-1:0]      ms_pc;
  logic                 ms_mem_req, ms_load_op, ms_rf_we;
  logic [LD_TYPE_W-1:0] ms_ld_type;
  logic [RF_AW-1:0]     ms_rf_addr;
  logic [DATA_W-1:0]    ms_alu_result;

  assign ms_alu_result = bus_q[DATA_W-1:0];
  assign ms_rf_addr    = bus_q[RFA_LSB +: RF_AW];
  assign ms_rf_we      = bus_q[RFWE_BIT];
  assign ms_ld_type    = bus_q[LDT_LSB +: LD_TYPE_W];
  assign ms_load_op    = bus_q[LOAD_BIT];
  assign ms_mem_req    = bus_q[MREQ_BIT];
  assign ms_pc         = bus_q[PC_LSB +: PC_W];

  logic ms_valid, in_wait, drop_pending, resp_own, ms_ready_go;
  logic es_accept, ws_handoff, drop_inc, drop_dec;
  logic [DATA_W-1:0] load_raw, load_data, rf_wdata;

  assign ms_valid     = (state_q != MS_EMPTY);
  assign in_wait      = (state_q == MS_WAIT);
  assign drop_pending = (drop_cnt_q != '0);
  // A response belongs to the held entry only when no flushed responses are still ahead of it.
  assign resp_own     = data_data_ok & ~drop_pending;
  assign ms_ready_go  = (state_q == MS_DONE) | (in_wait & resp_own);

  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
  assign es_accept      = es_to_ms_valid & ms_allowin & ~flush;
  assign ws_handoff     = ms_to_ws_valid & ws_allowin;

  assign drop_dec = data_data_ok & drop_pending;
  assign drop_inc = flush & in_wait & ~resp_own;

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    rdata_buf_d = rdata_buf_q;
    drop_cnt_d  = drop_cnt_q;

    if (in_wait && resp_own) rdata_buf_d = data_rdata;

    if (flush) begin
      state_d = MS_EMPTY;
    end else if (es_accept) begin
      bus_d   = es_to_ms_bus;
      state_d = es_to_ms_bus[MREQ_BIT] ? MS_WAIT : MS_DONE;
    end else if (ws_handoff) begin
      state_d = MS_EMPTY;
    end else if (in_wait && resp_own) begin
      state_d = MS_DONE;
    end

    if (drop_inc && !drop_dec)      drop_cnt_d = drop_cnt_q + 1'b1;
    else if (drop_dec && !drop_inc) drop_cnt_d = drop_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MS_EMPTY;
      bus_q       <= '0;
      rdata_buf_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      rdata_buf_q <= rdata_buf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // In WAIT the response is used live; once buffered (DONE) the stored copy is used.
  assign load_raw = in_wait ? data_rdata : rdata_buf_q;

  mem_stage_lsu_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .ld_type (ms_ld_type),
    .off     (ms_alu_result[OFF_W-1:0]),
    .rdata   (load_raw),
    .data_o  (load_data)
  );

  assign rf_wdata     = (ms_mem_req & ms_load_op) ? load_data : ms_alu_result;
  assign ms_to_ws_bus = {ms_pc, ms_rf_we, ms_rf_addr, rf_wdata};

  assign ms_fwd_we    = ms_valid & ms_rf_we;
  assign ms_fwd_addr  = ms_rf_addr;
  assign ms_fwd_block = in_wait & ms_load_op & ~resp_own;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(data_data_ok && !drop_pending && !in_wait));
      assert (!(es_accept && drop_cnt_q == DROP_MAX));
      assert (!(drop_inc && !drop_dec && drop_cnt_q == DROP_MAX));
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed vector bench for mem_stage_lsu at DATA_W 32 and 64
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel64, flush, ws_allowin, es_valid, data_ok;
  logic [31:0] pc;
  logic        mem_req, load_op, rf_we;
  logic [2:0]  ld_type;
  logic [4:0]  rf_addr;
  logic [63:0] alu, rdata;

  logic [74:0]  bus32;
  logic [106:0] bus64;
  logic [69:0]  ws32;
  logic [101:0] ws64;
  logic         v32, v64, a32, a64, fwe32, fwe64, fb32, fb64;
  logic [4:0]   fa32, fa64;

  logic        o_valid, o_allowin, o_fwd_we, o_fwd_block;
  logic [4:0]  o_fwd_addr, o_rf_addr;
  logic [31:0] o_pc;
  logic [63:0] o_wdata;

  assign bus32 = {pc, mem_req, load_op, ld_type, rf_we, rf_addr, alu[31:0]};
  assign bus64 = {pc, mem_req, load_op, ld_type, rf_we, rf_addr, alu};

  assign o_valid     = sel64 ? v64 : v32;
  assign o_allowin   = sel64 ? a64 : a32;
  assign o_fwd_we    = sel64 ? fwe64 : fwe32;
  assign o_fwd_addr  = sel64 ? fa64 : fa32;
  assign o_fwd_block = sel64 ? fb64 : fb32;
  assign o_wdata     = sel64 ? ws64[63:0] : {32'h0, ws32[31:0]};
  assign o_rf_addr   = sel64 ? ws64[68:64] : ws32[36:32];
  assign o_pc        = sel64 ? ws64[101:70] : ws32[69:38];

  mem_stage_lsu #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush & ~sel64), .ws_allowin(ws_allowin),
    .ms_allowin(a32), .es_to_ms_valid(es_valid & ~sel64), .es_to_ms_bus(bus32),
    .ms_to_ws_valid(v32), .ms_to_ws_bus(ws32), .data_data_ok(data_ok & ~sel64),
    .data_rdata(rdata[31:0]), .ms_fwd_we(fwe32), .ms_fwd_addr(fa32), .ms_fwd_block(fb32)
  );

  mem_stage_lsu #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush & sel64), .ws_allowin(ws_allowin),
    .ms_allowin(a64), .es_to_ms_valid(es_valid & sel64), .es_to_ms_bus(bus64),
    .ms_to_ws_valid(v64), .ms_to_ws_bus(ws64), .data_data_ok(data_ok & sel64),
    .data_rdata(rdata), .ms_fwd_we(fwe64), .ms_fwd_addr(fa64), .ms_fwd_block(fb64)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic mr, input logic lo, input logic [2:0] lt,
                       input logic [4:0] ra, input logic [63:0] a);
    mem_req  = mr;
    load_op  = lo;
    ld_type  = lt;
    rf_we    = lo | ~mr;
    rf_addr  = ra;
    alu      = a;
    pc       = 32'h400 + {25'h0, ra, 2'b00};
    es_valid = 1'b1;
  endtask

  typedef struct {
    logic        w64;
    logic [2:0]  lt;
    logic        lo;
    logic [63:0] a;
    logic [63:0] rd;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b0, LD_LB,  1'b1, 64'h1003, 64'h80FF_FF00, 64'hFFFF_FF80};
    vecs[1]  = '{1'b0, LD_LBU, 1'b1, 64'h1003, 64'h80FF_FF00, 64'h0000_0080};
    vecs[2]  = '{1'b0, LD_LB,  1'b1, 64'h1000, 64'h1234_5678, 64'h0000_0078};
    vecs[3]  = '{1'b0, LD_LB,  1'b1, 64'h1001, 64'h0000_9A00, 64'hFFFF_FF9A};
    vecs[4]  = '{1'b0, LD_LH,  1'b1, 64'h1000, 64'h1234_8001, 64'hFFFF_8001};
    vecs[5]  = '{1'b0, LD_LHU, 1'b1, 64'h1000, 64'h1234_8001, 64'h0000_8001};
    vecs[6]  = '{1'b0, LD_LH,  1'b1, 64'h1002, 64'h7FFF_0000, 64'h0000_7FFF};
    vecs[7]  = '{1'b0, LD_LHU, 1'b1, 64'h1002, 64'h8000_1234, 64'h0000_8000};
    vecs[8]  = '{1'b0, LD_LW,  1'b1, 64'h1000, 64'hCAFE_F00D, 64'hCAFE_F00D};
    vecs[9]  = '{1'b0, LD_LW,  1'b0, 64'hDEAD_BEE0, 64'h1111_1111, 64'hDEAD_BEE0};
    vecs[10] = '{1'b1, LD_LW,  1'b1, 64'h2004, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001};
    vecs[11] = '{1'b1, LD_LWU, 1'b1, 64'h2004, 64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001};
    vecs[12] = '{1'b1, LD_LD,  1'b1, 64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[13] = '{1'b1, LD_LB,  1'b1, 64'h2007, 64'h8500_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF85};
    vecs[14] = '{1'b1, LD_LH,  1'b1, 64'h2002, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D};

    reset = 1'b1; sel64 = 1'b0; flush = 1'b0; ws_allowin = 1'b1; es_valid = 1'b0; data_ok = 1'b0;
    pc = '0; mem_req = 1'b0; load_op = 1'b0; rf_we = 1'b0; ld_type = '0; rf_addr = '0;
    alu = '0; rdata = '0;
    step(); step();
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      chk($sformatf("rst_valid%0d", s), {63'h0, o_valid}, 64'h0);
      chk($sformatf("rst_allowin%0d", s), {63'h0, o_allowin}, 64'h1);
      chk($sformatf("rst_fwd%0d", s), {57'h0, o_fwd_we, o_fwd_block, o_fwd_addr}, 64'h0);
    end
    sel64 = 1'b0;
    reset = 1'b0;
    step();

    // ALU op: one-cycle stage
    issue(1'b0, 1'b0, 3'd0, 5'd5, 64'h1234);
    @(negedge clk); chk("alu_accept", {63'h0, o_allowin}, 64'h1);
    step(); es_valid = 1'b0;
    @(negedge clk);
    chk("alu_valid", {63'h0, o_valid}, 64'h1);
    chk("alu_wdata", o_wdata, 64'h1234);
    chk("alu_fwd", {57'h0, o_fwd_we, o_fwd_block, o_fwd_addr}, {57'h0, 2'b10, 5'd5});
    chk("alu_pc", {32'h0, o_pc}, 64'h414);
    step();
    @(negedge clk); chk("alu_gone", {63'h0, o_valid}, 64'h0);
    step();

    for (int i = 0; i < NV; i++) begin
      sel64 = vecs[i].w64;
      issue(1'b1, vecs[i].lo, vecs[i].lt, 5'(i + 1), vecs[i].a);
      @(negedge clk); chk($sformatf("v%0d_accept", i), {63'h0, o_allowin}, 64'h1);
      step(); es_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_wait", i), {62'h0, o_valid, o_fwd_block}, {62'h0, 1'b0, vecs[i].lo});
      step(); data_ok = 1'b1; rdata = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {63'h0, o_valid}, 64'h1);
      chk($sformatf("v%0d_wdata", i), o_wdata, vecs[i].exp);
      chk($sformatf("v%0d_addr", i), {59'h0, o_rf_addr}, 64'(i + 1));
      step(); data_ok = 1'b0;
      @(negedge clk); chk($sformatf("v%0d_gone", i), {63'h0, o_valid}, 64'h0);
      step();
    end
    sel64 = 1'b0;

    // Response arrives while ws stalls: buffered, released 3 cycles later
    issue(1'b1, 1'b1, LD_LH, 5'd9, 64'h1002);
    step(); es_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 64'h7FFF_0000;
    @(negedge clk);
    chk("buf_live_valid", {63'h0, o_valid}, 64'h1);
    chk("buf_live_allowin", {63'h0, o_allowin}, 64'h0);
    step(); data_ok = 1'b0; rdata = 64'hFFFF_FFFF;
    issue(1'b0, 1'b0, 3'd0, 5'd7, 64'h55AA);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("buf_hold%0d_wdata", c), o_wdata, 64'h7FFF);
      chk($sformatf("buf_hold%0d_flags", c), {61'h0, o_valid, o_allowin, o_fwd_block}, 64'b100);
      step();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("buf_rel_flags", {62'h0, o_valid, o_allowin}, 64'b11);
    chk("buf_rel_wdata", o_wdata, 64'h7FFF);
    chk("buf_rel_addr", {59'h0, o_rf_addr}, 64'd9);
    step(); es_valid = 1'b0;
    @(negedge clk);
    chk("b2b_alu_wdata", o_wdata, 64'h55AA);
    chk("b2b_alu_fwd", {57'h0, o_fwd_we, o_fwd_block, o_fwd_addr}, {57'h0, 2'b10, 5'd7});
    step();
    @(negedge clk); chk("b2b_gone", {63'h0, o_valid}, 64'h0);
    step();

    // Flush in WAIT: the next response is dropped, the one after is delivered
    issue(1'b1, 1'b1, LD_LW, 5'd3, 64'h3000);
    step(); es_valid = 1'b0; flush = 1'b1;
    @(negedge clk); chk("fl_valid", {63'h0, o_valid}, 64'h0);
    step(); flush = 1'b0;
    issue(1'b1, 1'b1, LD_LW, 5'd4, 64'h3004);
    @(negedge clk); chk("fl_next_accept", {63'h0, o_allowin}, 64'h1);
    step(); es_valid = 1'b0; data_ok = 1'b1; rdata = 64'h1111_2222;
    @(negedge clk); chk("fl_drop", {62'h0, o_valid, o_fwd_block}, 64'b01);
    step(); rdata = 64'hCAFE_F00D;
    @(negedge clk);
    chk("fl_deliver_valid", {63'h0, o_valid}, 64'h1);
    chk("fl_deliver_wdata", o_wdata, 64'hCAFE_F00D);
    step(); data_ok = 1'b0;
    @(negedge clk); chk("fl_gone", {62'h0, o_valid, o_allowin}, 64'b01);
    step();

    // Flush and data_ok together with nothing pending: response consumed, no drop queued
    issue(1'b1, 1'b1, LD_LW, 5'd6, 64'h3008);
    step(); es_valid = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 64'hBAD0_BAD0;
    @(negedge clk); chk("fd_valid", {63'h0, o_valid}, 64'h0);
    step(); flush = 1'b0; data_ok = 1'b0;
    issue(1'b1, 1'b1, LD_LW, 5'd8, 64'h300C);
    step(); es_valid = 1'b0; data_ok = 1'b1; rdata = 64'h1357_9BDF;
    @(negedge clk);
    chk("fd_next_valid", {63'h0, o_valid}, 64'h1);
    chk("fd_next_wdata", o_wdata, 64'h1357_9BDF);
    step(); data_ok = 1'b0;
    step();

    // Flush and data_ok together while a drop is pending: count stays at one
    issue(1'b1, 1'b1, LD_LW, 5'd10, 64'h3010);
    step(); es_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    issue(1'b1, 1'b1, LD_LW, 5'd11, 64'h3014);
    step(); es_valid = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 64'hAAAA_0001;
    @(negedge clk); chk("fdp_valid", {63'h0, o_valid}, 64'h0);
    step(); flush = 1'b0; data_ok = 1'b0;
    issue(1'b1, 1'b1, LD_LW, 5'd12, 64'h3018);
    step(); es_valid = 1'b0; data_ok = 1'b1; rdata = 64'hAAAA_0002;
    @(negedge clk); chk("fdp_drop", {63'h0, o_valid}, 64'h0);
    step(); rdata = 64'h2468_ACE0;
    @(negedge clk);
    chk("fdp_valid2", {63'h0, o_valid}, 64'h1);
    chk("fdp_wdata", o_wdata, 64'h2468_ACE0);
    step(); data_ok = 1'b0;
    step();

    // Reset while the 64-bit stage waits on a load
    sel64 = 1'b1;
    issue(1'b1, 1'b1, LD_LD, 5'd13, 64'h4000);
    step(); es_valid = 1'b0;
    @(negedge clk); chk("rw_block", {63'h0, o_fwd_block}, 64'h1);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("rw_flags", {62'h0, o_valid, o_allowin}, 64'b01);
    chk("rw_fwd", {57'h0, o_fwd_we, o_fwd_block, o_fwd_addr}, 64'h0);
    issue(1'b1, 1'b1, LD_LW, 5'd14, 64'h4004);
    step(); es_valid = 1'b0; data_ok = 1'b1; rdata = 64'h7000_0002_0000_0000;
    @(negedge clk);
    chk("rw_next_valid", {63'h0, o_valid}, 64'h1);
    chk("rw_next_wdata", o_wdata, 64'h0000_0000_7000_0002);
    step(); data_ok = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
